// File: rtl/register_file.sv
// Architectural register file x0..x31 with ROB rename tags.
// Commit/rename write port plus two combinational operand-resolve ports.
module register_file #(
  parameter int ROB_WIDTH_BIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic [4:0]               set_reg_id,
  input  logic [31:0]              set_val,
  input  logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
  input  logic [4:0]               set_dep_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id,
  input  logic [4:0]               rs1_id,
  input  logic [4:0]               rs2_id,
  output logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
  output logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
  input  logic                     rob_value1_ready,
  input  logic                     rob_value2_ready,
  input  logic [31:0]              rob_value1,
  input  logic [31:0]              rob_value2,
  output logic [31:0]              val1,
  output logic [31:0]              val2,
  output logic                     has_dep1,
  output logic                     has_dep2,
  output logic [ROB_WIDTH_BIT-1:0] dep1,
  output logic [ROB_WIDTH_BIT-1:0] dep2
);

  localparam int RW = ROB_WIDTH_BIT;

  typedef struct packed {
    logic [31:0]   val;
    logic          has_dep;
    logic [RW-1:0] dep;
    logic [RW-1:0] tag;
  } rd_t;

  logic [31:0][31:0]   value_q, value_d;
  logic [31:0]         busy_q, busy_d;
  logic [31:0][RW-1:0] tag_q, tag_d;

  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (clear) begin
      busy_d = '0;
    end else if (rdy_in) begin
      if (set_reg_id != 5'd0) begin
        value_d[set_reg_id] = set_val;
        // a younger rename keeps ownership of rd
        if (tag_q[set_reg_id] == set_reg_on_rob_id)
          busy_d[set_reg_id] = 1'b0;
      end
      if (set_dep_reg_id != 5'd0) begin
        busy_d[set_dep_reg_id] = 1'b1;
        tag_d[set_dep_reg_id]  = set_dep_rob_id;
      end
    end
    value_d[0] = '0;
    busy_d[0]  = 1'b0;
    tag_d[0]   = '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      value_q <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  function automatic rd_t resolve(
    input logic [4:0]    r,
    input logic          b,
    input logic [31:0]   v,
    input logic [RW-1:0] t,
    input logic          qr,
    input logic [31:0]   qv,
    input logic [4:0]    cid,
    input logic [RW-1:0] crob,
    input logic [31:0]   cval
  );
    rd_t o;
    o = '0;
    if (r != 5'd0) begin
      o.tag = t;
      if (!b) begin
        o.val = v;
      end else if (cid == r && crob == t) begin
        o.val = cval;
      end else if (qr) begin
        o.val = qv;
      end else begin
        o.has_dep = 1'b1;
        o.dep     = t;
      end
    end
    return o;
  endfunction

  rd_t rd1, rd2;

  always_comb begin
    rd1 = resolve(rs1_id, busy_q[rs1_id], value_q[rs1_id],
                  tag_q[rs1_id], rob_value1_ready, rob_value1,
                  set_reg_id, set_reg_on_rob_id, set_val);
    rd2 = resolve(rs2_id, busy_q[rs2_id], value_q[rs2_id],
                  tag_q[rs2_id], rob_value2_ready, rob_value2,
                  set_reg_id, set_reg_on_rob_id, set_val);
  end

  assign val1        = rd1.val;
  assign has_dep1    = rd1.has_dep;
  assign dep1        = rd1.dep;
  assign get_rob_id1 = rd1.tag;
  assign val2        = rd2.val;
  assign has_dep2    = rd2.has_dep;
  assign dep2        = rd2.dep;
  assign get_rob_id2 = rd2.tag;

endmodule
